fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of decode and the pipeline controller.
- Issues 16-bit instruction reads to instruction memory over a req/ack handshake and buffers returned words in a 2-entry FIFO.
- Presents the FIFO head to decode, supplying PC_in/three_msb/thirteen_lsb to the controller.
- Consumes the controller's predicted next PC and stall vector, plus a late redirect from execute on misprediction.

Parameters:
- RESET_PC, 16'h0000, first fetch address after reset
- BUF_DEPTH, 2, fetch FIFO entries (fixed at 2; other values unsupported)

Ports:
- clk  in  1  system clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- pc_next_in  in  16  predicted next PC from pipeline controller for the current head instruction
- stall  in  8  controller stall vector; any nonzero bit blocks decode acceptance
- redirect_valid  in  1  execute-stage mispredict; overrides everything
- redirect_pc  in  16  corrected PC (LBPC/LBPC_LR value)
- imem_req  out  1  read request to instruction memory
- imem_addr  out  16  word-aligned read address
- imem_ack  in  1  read complete; imem_rdata valid this cycle
- imem_rdata  in  16  instruction word
- if_valid  out  1  FIFO head valid for decode
- if_instr  out  16  head instruction
- pc_out  out  16  head PC (drives controller PC_in)
- three_msb  out  3  if_instr[15:13]
- thirteen_lsb  out  13  if_instr[12:0]

Behaviour:
- Reset (rst=1 at posedge):
  - imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, pc_out=0.
  - FIFO empty; fetch_pc=RESET_PC; state IDLE.
  - Reset overrides any outstanding transaction. imem_req drops the next cycle; a later stale imem_ack is ignored.
- States:
  - IDLE: no request. Go to WAIT when count+0 < 2; drive imem_req=1, imem_addr=fetch_pc.
  - WAIT: hold imem_req=1 and imem_addr stable until imem_ack. Never abort a request.
    - On ack: push {fetch_pc, imem_rdata}; fetch_pc += 2, wrapping 16'hFFFE -> 16'h0000.
    - Then return to IDLE. Back-to-back issue is allowed next cycle if space remains.
  - DISCARD: entered from WAIT on a redirect. Keep the request until ack, drop that data, go to IDLE. fetch_pc already holds the new target.
- imem_ack outside WAIT/DISCARD is ignored. Earliest legal ack is the cycle after req rises.
- Pop: occurs when if_valid=1 and stall==8'h00.
- Predicted redirect on pop:
  - If pc_next_in != head_pc+2, flush the FIFO (including the entry pushed this cycle) and set fetch_pc=pc_next_in.
  - If in WAIT, go to DISCARD.
- External redirect (redirect_valid=1):
  - Flush FIFO; fetch_pc=redirect_pc; WAIT->DISCARD. Takes priority over pop and push in the same cycle.
  - The head is not consumed that cycle; if_valid=0 the next cycle.
- Address bit 0 is forced to 0 on every load of fetch_pc.
- Simultaneous push and pop with no redirect: count unchanged; order preserved.
- Full FIFO (count=2): no new issue. An in-flight ack always has a slot, since issue requires count+1 <= 2.
- Latency:
  - redirect at posedge N -> imem_req with new address visible after N if idle, else after the discard ack.
  - ack at posedge M -> if_valid=1 with that instruction after M.
- Output fields are combinational from the FIFO head register and are 0 when empty.

Test Plan:
- Reset, then 1-cycle-latency memory returning 16'h4000+addr -> first req addr 0x0000; if_valid after 2 cycles; pc_out sequence 0,2,4 with stall=0.
- stall=8'h01 held 5 cycles, memory always ack -> exactly 2 entries buffered; imem_req low while full; release yields PCs in order, none lost or duplicated.
- Head PC 0x0010, pc_next_in=0x0040 at pop -> FIFO flushed; next imem_addr=0x0040; next if_valid instruction has pc_out=0x0040.
- redirect_valid with redirect_pc=0x0101 while WAIT (ack delayed 3 cycles) -> req held at old addr until ack; data discarded; next req addr=0x0100.
- fetch_pc=0xFFFE sequential -> after 0xFFFE, next imem_addr=0x0000.
- rst asserted in WAIT, ack arrives 1 cycle later -> ack ignored; if_valid=0; first post-reset req addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues 16-bit imem reads over req/ack and buffers up to
// two returned words for decode, honouring predicted and execute-stage redirects.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_next_in,
    input  logic [7:0]  stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] pc_out,
    output logic [2:0]  three_msb,
    output logic [12:0] thirteen_lsb
);

    localparam int unsigned PC_W  = 16;
    localparam int unsigned CNT_W = 2;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]      state, state_nx;
    logic [PC_W-1:0] fetch_pc, fetch_pc_nx;
    logic            req_q, req_nx;
    logic [PC_W-1:0] addr_q, addr_nx;

    // Two-slot shift FIFO; slot 0 is the head presented to decode.
    logic            v0, v1, v0_nx, v1_nx;
    logic [PC_W-1:0] pc0, pc1, pc0_nx, pc1_nx;
    logic [PC_W-1:0] ins0, ins1, ins0_nx, ins1_nx;

    logic [CNT_W-1:0] count;
    logic [PC_W-1:0]  seq_pc;
    logic [PC_W-1:0]  target_raw;
    logic [PC_W-1:0]  target;
    logic             pop;
    logic             flush;
    logic             push;

    assign count      = CNT_W'(v0) + CNT_W'(v1);
    assign seq_pc     = pc0 + PC_W'(2);
    assign pop        = v0 && (stall == 8'h00) && !redirect_valid;
    assign flush      = redirect_valid || (pop && (pc_next_in != seq_pc));
    assign target_raw = redirect_valid ? redirect_pc : pc_next_in;
    assign target     = {target_raw[PC_W-1:1], 1'b0};
    assign push       = (state == S_WAIT) && imem_ack && !flush;

    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        req_nx      = req_q;
        addr_nx     = addr_q;
        v0_nx       = v0;
        pc0_nx      = pc0;
        ins0_nx     = ins0;
        v1_nx       = v1;
        pc1_nx      = pc1;
        ins1_nx     = ins1;

        case (state)
            S_IDLE: begin
                if (flush || (32'(count) < BUF_DEPTH)) begin
                    state_nx = S_WAIT;
                    req_nx   = 1'b1;
                    addr_nx  = flush ? target : fetch_pc;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    state_nx    = S_IDLE;
                    req_nx      = 1'b0;
                    fetch_pc_nx = {fetch_pc[PC_W-1:1] + 15'd1, 1'b0};
                end else if (flush) begin
                    state_nx = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (imem_ack) begin
                    state_nx = S_IDLE;
                    req_nx   = 1'b0;
                end
            end
            default: begin
                state_nx = S_IDLE;
                req_nx   = 1'b0;
            end
        endcase

        // A redirect target always wins over the sequential increment.
        if (flush) begin
            fetch_pc_nx = target;
        end

        if (pop) begin
            v0_nx   = v1;
            pc0_nx  = pc1;
            ins0_nx = ins1;
            v1_nx   = 1'b0;
            pc1_nx  = '0;
            ins1_nx = '0;
        end

        if (push) begin
            if (!v0_nx) begin
                v0_nx   = 1'b1;
                pc0_nx  = fetch_pc;
                ins0_nx = imem_rdata;
            end else begin
                v1_nx   = 1'b1;
                pc1_nx  = fetch_pc;
                ins1_nx = imem_rdata;
            end
        end

        if (flush) begin
            v0_nx   = 1'b0;
            pc0_nx  = '0;
            ins0_nx = '0;
            v1_nx   = 1'b0;
            pc1_nx  = '0;
            ins1_nx = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            fetch_pc <= {RESET_PC[PC_W-1:1], 1'b0};
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            v0       <= 1'b0;
            pc0      <= '0;
            ins0     <= '0;
            v1       <= 1'b0;
            pc1      <= '0;
            ins1     <= '0;
        end else begin
            state    <= state_nx;
            fetch_pc <= fetch_pc_nx;
            req_q    <= req_nx;
            addr_q   <= addr_nx;
            v0       <= v0_nx;
            pc0      <= pc0_nx;
            ins0     <= ins0_nx;
            v1       <= v1_nx;
            pc1      <= pc1_nx;
            ins1     <= ins1_nx;
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = addr_q;
    assign if_valid     = v0;
    assign if_instr     = ins0;
    assign pc_out       = pc0;
    assign three_msb    = ins0[15:13];
    assign thirteen_lsb = ins0[12:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder, directed redirect table, hand-written
// corner sequences and a randomized run against an architectural-PC model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_next_in;
    logic [7:0]  stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] pc_out;
    logic [2:0]  three_msb;
    logic [12:0] thirteen_lsb;

    int vectors     = 0;
    int miscompares = 0;

    logic        mem_en    = 1'b0;
    logic        man_ack   = 1'b0;
    logic [15:0] man_rdata = 16'h0000;
    logic        rsp_ack   = 1'b0;
    logic [15:0] rsp_rdata = 16'h0000;
    logic        busy      = 1'b0;
    int          lat       = 0;
    int          lat_min   = 1;
    int          lat_max   = 1;
    logic [15:0] req_addr  = 16'h0000;
    logic [15:0] issued[$];

    assign imem_ack   = mem_en ? rsp_ack : man_ack;
    assign imem_rdata = mem_en ? rsp_rdata : man_rdata;

    fetch_unit #(.RESET_PC(16'h0000), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_next_in     (pc_next_in),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .pc_out         (pc_out),
        .three_msb      (three_msb),
        .thirteen_lsb   (thirteen_lsb)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'h4000 + a;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    task automatic chk_issued(input string name, input int idx, input logic [15:0] exp);
        if (issued.size() > idx) chk(name, issued[idx], exp);
        else timeout(name);
    endtask

    // Memory: acks each request after lat_min..lat_max cycles with 0x4000+addr.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rsp_ack = 1'b0;
            if (!mem_en) begin
                busy = 1'b0;
            end else begin
                if (busy) begin
                    chk("req_hold", 16'(imem_req), 16'h0001);
                    chk("addr_hold", imem_addr, req_addr);
                end else if (imem_req) begin
                    busy     = 1'b1;
                    req_addr = imem_addr;
                    lat      = int'($urandom_range(lat_max, lat_min));
                    issued.push_back(imem_addr);
                    chk("addr_align", 16'(imem_addr[0]), 16'h0000);
                end
                if (busy) begin
                    lat--;
                    if (lat == 0) begin
                        rsp_ack   = 1'b1;
                        rsp_rdata = mem_word(req_addr);
                        busy      = 1'b0;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        mem_en         = 1'b0;
        man_ack        = 1'b0;
        stall          = 8'h00;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        mem_en = 1'b1;
    endtask

    task automatic step_pop(input string name, input int budget, input logic [15:0] exp_pc);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            redirect_valid = 1'b0;
            stall          = 8'h00;
            pc_next_in     = pc_out + 16'd2;
            if (if_valid) begin
                ok = 1'b1;
                chk({name, "_pc"}, pc_out, exp_pc);
                chk({name, "_instr"}, if_instr, mem_word(exp_pc));
                break;
            end
        end
        if (!ok) timeout(name);
    endtask

    task automatic wait_head(input string name, input int budget, input logic [15:0] pc);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            redirect_valid = 1'b0;
            if (if_valid && (pc_out == pc)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout(name);
    endtask

    task automatic wait_valid(input string name, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            redirect_valid = 1'b0;
            if (if_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout(name);
    endtask

    typedef struct {
        logic        ext;
        logic [15:0] from_pc;
        logic [15:0] target;
        logic [15:0] exp_addr;
        logic [15:0] exp_instr;
    } redir_vec_t;

    redir_vec_t tbl [6];

    initial begin
        redir_vec_t  e;
        logic        prev;
        logic        found;
        logic [15:0] old_addr;
        logic [15:0] exp_pc;
        logic [15:0] ei;
        logic        exp_invalid;
        int          pops;

        tbl[0] = '{1'b0, 16'h0010, 16'h0040, 16'h0040, 16'h4040};
        tbl[1] = '{1'b1, 16'h0200, 16'h0101, 16'h0100, 16'h4100};
        tbl[2] = '{1'b0, 16'h0020, 16'h0021, 16'h0020, 16'h4020};
        tbl[3] = '{1'b1, 16'h0300, 16'hFFFF, 16'hFFFE, 16'h3FFE};
        tbl[4] = '{1'b0, 16'h1000, 16'h1003, 16'h1002, 16'h5002};
        tbl[5] = '{1'b1, 16'h0400, 16'h7FFE, 16'h7FFE, 16'hBFFE};

        rst = 1'b1; stall = 8'h00; redirect_valid = 1'b0; redirect_pc = 16'h0000; pc_next_in = 16'h0000;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req", 16'(imem_req), 16'h0000);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_valid", 16'(if_valid), 16'h0000);
        chk("rst_instr", if_instr, 16'h0000);
        chk("rst_pc", pc_out, 16'h0000);
        chk("rst_msb", 16'(three_msb), 16'h0000);
        chk("rst_lsb", 16'(thirteen_lsb), 16'h0000);

        // Sequential fetch with single-cycle memory
        lat_min = 1; lat_max = 1;
        issued.delete();
        rst = 1'b0; mem_en = 1'b1;
        @(negedge clk);
        chk("first_req", 16'(imem_req), 16'h0001);
        chk("first_addr", imem_addr, 16'h0000);
        chk("first_valid", 16'(if_valid), 16'h0000);
        step_pop("seq0", 1, 16'h0000);
        step_pop("seq1", 4, 16'h0002);
        step_pop("seq2", 4, 16'h0004);
        chk_issued("seq_issue0", 0, 16'h0000);

        // Stall holds the FIFO full; both buffered words then drain back to back
        do_reset();
        stall = 8'h01;
        issued.delete();
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i >= 5) chk("full_req_low", 16'(imem_req), 16'h0000);
        end
        chk("full_issued", 16'(issued.size()), 16'h0002);
        chk("full_head", pc_out, 16'h0000);
        step_pop("drain0", 1, 16'h0000);
        step_pop("drain1", 1, 16'h0002);
        step_pop("drain2", 6, 16'h0004);
        step_pop("drain3", 6, 16'h0006);

        // Redirect table: predicted (on pop) and external (during WAIT)
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 6; i++) begin
            e = tbl[i];
            @(negedge clk);
            stall = 8'h01; redirect_valid = 1'b1; redirect_pc = e.from_pc;
            wait_head($sformatf("redir%0d_setup", i), 40, e.from_pc);
            if (!e.ext) begin
                issued.delete();
                stall = 8'h00; pc_next_in = e.target;
                @(negedge clk);
                stall = 8'h01;
                chk($sformatf("redir%0d_flush", i), 16'(if_valid), 16'h0000);
            end else begin
                prev = imem_req; found = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    if (!prev && imem_req) begin found = 1'b1; break; end
                    prev = imem_req;
                end
                if (!found) timeout($sformatf("redir%0d_wait_req", i));
                issued.delete();
                old_addr = imem_addr;
                redirect_valid = 1'b1; redirect_pc = e.target;
                @(negedge clk);
                redirect_valid = 1'b0;
                chk($sformatf("redir%0d_flush", i), 16'(if_valid), 16'h0000);
                chk($sformatf("redir%0d_req_held", i), 16'(imem_req), 16'h0001);
                chk($sformatf("redir%0d_addr_held", i), imem_addr, old_addr);
            end
            wait_valid($sformatf("redir%0d_valid", i), 20);
            chk_issued($sformatf("redir%0d_addr", i), 0, e.exp_addr);
            chk($sformatf("redir%0d_pc", i), pc_out, e.exp_addr);
            chk($sformatf("redir%0d_instr", i), if_instr, e.exp_instr);
        end

        // Address wrap from 0xFFFE to 0x0000
        lat_min = 1; lat_max = 1;
        @(negedge clk);
        stall = 8'h00; redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        issued.delete();
        step_pop("wrap0", 12, 16'hFFFE);
        step_pop("wrap1", 6, 16'h0000);
        step_pop("wrap2", 6, 16'h0002);
        chk_issued("wrap_issue0", 0, 16'hFFFE);
        chk_issued("wrap_issue1", 1, 16'h0000);

        // Reset during WAIT, stale ack one cycle later
        do_reset();
        mem_en = 1'b0;
        issued.delete();
        @(negedge clk);
        chk("rw_req_up", 16'(imem_req), 16'h0001);
        rst = 1'b1;
        @(negedge clk);
        chk("rw_req_drop", 16'(imem_req), 16'h0000);
        chk("rw_valid0", 16'(if_valid), 16'h0000);
        rst = 1'b0; man_ack = 1'b1; man_rdata = 16'hDEAD;
        @(negedge clk);
        man_ack = 1'b0;
        chk("rw_valid1", 16'(if_valid), 16'h0000);
        chk("rw_req", 16'(imem_req), 16'h0001);
        chk("rw_addr", imem_addr, 16'h0000);
        @(negedge clk);
        chk("rw_valid2", 16'(if_valid), 16'h0000);
        mem_en = 1'b1;
        wait_valid("rw_recover", 10);
        chk("rw_pc", pc_out, 16'h0000);
        chk("rw_instr", if_instr, 16'h4000);
        chk_issued("rw_issue0", 0, 16'h0000);

        // Randomized run against the architectural next-PC model
        do_reset();
        lat_min = 1; lat_max = 3;
        exp_pc = 16'h0000; exp_invalid = 1'b0; pops = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (exp_invalid) chk("rnd_redir_invalid", 16'(if_valid), 16'h0000);
            exp_invalid = 1'b0;
            if (!if_valid) begin
                chk("rnd_empty_instr", if_instr, 16'h0000);
                chk("rnd_empty_pc", pc_out, 16'h0000);
            end
            stall          = ($urandom_range(3) == 0) ? 8'(1 << $urandom_range(7)) : 8'h00;
            redirect_valid = ($urandom_range(24) == 0);
            redirect_pc    = 16'($urandom);
            case ($urandom_range(9))
                0:       pc_next_in = 16'($urandom);
                1:       pc_next_in = pc_out + 16'd3;
                default: pc_next_in = pc_out + 16'd2;
            endcase
            if (redirect_valid) begin
                exp_pc      = {redirect_pc[15:1], 1'b0};
                exp_invalid = 1'b1;
            end else if (if_valid && (stall == 8'h00)) begin
                ei = mem_word(exp_pc);
                chk("rnd_pc", pc_out, exp_pc);
                chk("rnd_instr", if_instr, ei);
                chk("rnd_msb", 16'(three_msb), 16'(ei[15:13]));
                chk("rnd_lsb", 16'(thirteen_lsb), 16'(ei[12:0]));
                exp_pc = {pc_next_in[15:1], 1'b0};
                pops++;
            end
        end
        chk("rnd_progress", 16'(pops >= 100), 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
